// File: rtl/sda_ctrl_pkg.sv
// Shared opcodes, response codes and FSM states for the
// kernel action control master.
package sda_ctrl_pkg;

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_RUN   = 2'b10;
   localparam logic [1:0] OP_RSVD  = 2'b11;

   localparam logic [1:0] ST_OKAY   = 2'b00;
   localparam logic [1:0] ST_SLVERR = 2'b10;
   localparam logic [1:0] ST_DECERR = 2'b11;

   typedef enum logic [3:0] {
      S_IDLE,
      S_RD_A,
      S_RD_D,
      S_WR_AW,
      S_WR_B,
      S_GO_REQ,
      S_RUN,
      S_DONE_ACK,
      S_RSP
   } state_e;

endpackage

// File: rtl/sda_kernel_control_master.sv
// Single-outstanding command initiator driving an AXI-lite control
// slave and the go/done handshake of a kernel action.
module sda_kernel_control_master
   import sda_ctrl_pkg::*;
#(
   parameter logic [3:0] AXI_CACHE = 4'b0011,
   parameter logic [2:0] AXI_PROT  = 3'b000,
   parameter int         CNT_WIDTH = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   input  logic [3:0]  cmd_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [1:0]  rsp_status,
   output logic        go_0r,
   input  logic        go_0a,
   input  logic        done_0r,
   output logic        done_0a,
   output logic [31:0] m_axi_araddr,
   output logic [3:0]  m_axi_arcache,
   output logic [2:0]  m_axi_arprot,
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   input  logic [31:0] m_axi_rdata,
   input  logic [1:0]  m_axi_rresp,
   input  logic        m_axi_rvalid,
   output logic        m_axi_rready,
   output logic [31:0] m_axi_awaddr,
   output logic [3:0]  m_axi_awcache,
   output logic [2:0]  m_axi_awprot,
   output logic        m_axi_awvalid,
   input  logic        m_axi_awready,
   output logic [31:0] m_axi_wdata,
   output logic [3:0]  m_axi_wstrb,
   output logic        m_axi_wvalid,
   input  logic        m_axi_wready,
   input  logic [1:0]  m_axi_bresp,
   input  logic        m_axi_bvalid,
   output logic        m_axi_bready
);

   state_e state_q, state_d;

   logic                 cmd_ready_q, cmd_ready_d;
   logic                 arvalid_q, arvalid_d;
   logic                 rready_q, rready_d;
   logic                 awvalid_q, awvalid_d;
   logic                 wvalid_q, wvalid_d;
   logic                 bready_q, bready_d;
   logic                 go_q, go_d;
   logic                 done_a_q, done_a_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [31:0]          rsp_data_q, rsp_data_d;
   logic [1:0]           rsp_status_q, rsp_status_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [31:0]          addr_q, addr_d;
   logic [31:0]          wdata_q, wdata_d;
   logic [3:0]           wstrb_q, wstrb_d;

   logic [CNT_WIDTH-1:0] cnt_inc;
   logic [31:0]          cnt_ext;
   logic                 aw_done;
   logic                 w_done;

   always_comb begin
      cnt_inc = cnt_q;
      if (cnt_q != '1) cnt_inc = cnt_q + 1'b1;
      cnt_ext = '0;
      cnt_ext[CNT_WIDTH-1:0] = cnt_q;
   end

   // A channel counts as done once its valid has dropped or is taken now.
   assign aw_done = !awvalid_q || m_axi_awready;
   assign w_done  = !wvalid_q || m_axi_wready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cmd_ready_q  <= 1'b1;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         awvalid_q    <= 1'b0;
         wvalid_q     <= 1'b0;
         bready_q     <= 1'b0;
         go_q         <= 1'b0;
         done_a_q     <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_status_q <= '0;
         cnt_q        <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
      end else begin
         state_q      <= state_d;
         cmd_ready_q  <= cmd_ready_d;
         arvalid_q    <= arvalid_d;
         rready_q     <= rready_d;
         awvalid_q    <= awvalid_d;
         wvalid_q     <= wvalid_d;
         bready_q     <= bready_d;
         go_q         <= go_d;
         done_a_q     <= done_a_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         rsp_status_q <= rsp_status_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cmd_ready_d  = cmd_ready_q;
      arvalid_d    = arvalid_q;
      rready_d     = rready_q;
      awvalid_d    = awvalid_q;
      wvalid_d     = wvalid_q;
      bready_d     = bready_q;
      go_d         = go_q;
      done_a_d     = done_a_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_data_d   = rsp_data_q;
      rsp_status_d = rsp_status_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;

      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               cmd_ready_d = 1'b0;
               addr_d      = cmd_addr;
               wdata_d     = cmd_wdata;
               wstrb_d     = cmd_wstrb;
               unique case (cmd_op)
                  OP_READ: begin
                     arvalid_d = 1'b1;
                     state_d   = S_RD_A;
                  end
                  OP_WRITE: begin
                     awvalid_d = 1'b1;
                     wvalid_d  = 1'b1;
                     state_d   = S_WR_AW;
                  end
                  OP_RUN: begin
                     go_d    = 1'b1;
                     state_d = S_GO_REQ;
                  end
                  default: begin
                     rsp_valid_d  = 1'b1;
                     rsp_data_d   = '0;
                     rsp_status_d = ST_SLVERR;
                     state_d      = S_RSP;
                  end
               endcase
            end
         end
         S_RD_A: begin
            if (m_axi_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = S_RD_D;
            end
         end
         S_RD_D: begin
            if (m_axi_rvalid) begin
               rready_d     = 1'b0;
               rsp_valid_d  = 1'b1;
               rsp_data_d   = m_axi_rdata;
               rsp_status_d = m_axi_rresp;
               state_d      = S_RSP;
            end
         end
         S_WR_AW: begin
            awvalid_d = awvalid_q && !m_axi_awready;
            wvalid_d  = wvalid_q && !m_axi_wready;
            if (aw_done && w_done) begin
               bready_d = 1'b1;
               state_d  = S_WR_B;
            end
         end
         S_WR_B: begin
            if (m_axi_bvalid) begin
               bready_d     = 1'b0;
               rsp_valid_d  = 1'b1;
               rsp_data_d   = '0;
               rsp_status_d = m_axi_bresp;
               state_d      = S_RSP;
            end
         end
         S_GO_REQ: begin
            if (go_0a) begin
               go_d  = 1'b0;
               cnt_d = '0;
               // Responders may finish in the same cycle they acknowledge.
               if (done_0r) begin
                  done_a_d = 1'b1;
                  state_d  = S_DONE_ACK;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            cnt_d = cnt_inc;
            if (done_0r) begin
               done_a_d = 1'b1;
               state_d  = S_DONE_ACK;
            end
         end
         S_DONE_ACK: begin
            cnt_d    = cnt_inc;
            done_a_d = done_0r;
            if (!done_0r && !go_0a) begin
               done_a_d     = 1'b0;
               rsp_valid_d  = 1'b1;
               rsp_data_d   = cnt_ext;
               rsp_status_d = ST_OKAY;
               state_d      = S_RSP;
            end
         end
         S_RSP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d     = S_IDLE;
            cmd_ready_d = 1'b1;
         end
      endcase
   end

   assign cmd_ready     = cmd_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_data      = rsp_data_q;
   assign rsp_status    = rsp_status_q;
   assign go_0r         = go_q;
   assign done_0a       = done_a_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arcache = AXI_CACHE;
   assign m_axi_arprot  = AXI_PROT;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = rready_q;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awcache = AXI_CACHE;
   assign m_axi_awprot  = AXI_PROT;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_bready  = bready_q;

endmodule

// File: tb/tb_sda_kernel_control_master.sv
// Scoreboard bench for the kernel action control master.
module tb_sda_kernel_control_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_status;
   logic        go_0r, go_0a, done_0r, done_0a;
   logic [31:0] araddr;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid, arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid, rready;
   logic [31:0] awaddr;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid, awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid, wready;
   logic [1:0]  bresp;
   logic        bvalid, bready;

   typedef struct packed {
      logic [31:0] d;
      logic [1:0]  s;
   } exp_t;

   exp_t sb[$];
   int   n_pass = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   sda_kernel_control_master dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_status(rsp_status),
      .go_0r(go_0r), .go_0a(go_0a),
      .done_0r(done_0r), .done_0a(done_0a),
      .m_axi_araddr(araddr), .m_axi_arcache(arcache),
      .m_axi_arprot(arprot), .m_axi_arvalid(arvalid),
      .m_axi_arready(arready),
      .m_axi_rdata(rdata), .m_axi_rresp(rresp),
      .m_axi_rvalid(rvalid), .m_axi_rready(rready),
      .m_axi_awaddr(awaddr), .m_axi_awcache(awcache),
      .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
      .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
      .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
      .m_axi_bready(bready)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
      int n;
      n = 0;
      while (!cmd_ready && n < 50) begin
         tick();
         n++;
      end
      if (!cmd_ready) begin
         n_total++;
         $display("FAIL send_wait cmd_ready got 0 want 1");
      end
      cmd_op    = op;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_wstrb = s;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic get_rsp(output logic ok, output logic [31:0] d,
                          output logic [1:0] s);
      int n;
      ok = 1'b0;
      d  = '0;
      s  = '0;
      n  = 0;
      while (!rsp_valid && n < 300) begin
         tick();
         n++;
      end
      if (rsp_valid) begin
         ok = 1'b1;
         d  = rsp_data;
         s  = rsp_status;
         rsp_ready = 1'b1;
         tick();
         rsp_ready = 1'b0;
      end
   endtask

   task automatic pop_cmp(input string nm);
      logic ok;
      logic [31:0] d;
      logic [1:0] s;
      exp_t e;
      get_rsp(ok, d, s);
      e = sb.pop_front();
      n_total++;
      if (!ok)
         $display("FAIL %s rsp timeout got none want %h/%h", nm, e.d, e.s);
      else if (d !== e.d || s !== e.s)
         $display("FAIL %s rsp got %h/%h want %h/%h", nm, d, s, e.d, e.s);
      else n_pass++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      n_total++;
      if ({cmd_ready, rsp_valid, arvalid, awvalid, wvalid,
           rready, bready, go_0r, done_0a} !== 9'b1_0000_0000)
         $display("FAIL reset_ctl got %b want 100000000",
                  {cmd_ready, rsp_valid, arvalid, awvalid, wvalid,
                   rready, bready, go_0r, done_0a});
      else n_pass++;
      n_total++;
      if ({rsp_data, rsp_status} !== 34'h0)
         $display("FAIL reset_rsp got %h want 0", {rsp_data, rsp_status});
      else n_pass++;
      n_total++;
      if ({arcache, arprot, awcache, awprot} !== 14'b0011_000_0011_000)
         $display("FAIL cache_prot got %b want 00110000011000",
                  {arcache, arprot, awcache, awprot});
      else n_pass++;
   endtask

   task automatic test_write();
      sb.push_back('{d: 32'h0, s: 2'b00});
      send(2'b01, 32'h10, 32'hDEADBEEF, 4'hF);
      n_total++;
      if ({cmd_ready, awvalid, wvalid} !== 3'b011)
         $display("FAIL wr_t1 got %b want 011", {cmd_ready, awvalid, wvalid});
      else n_pass++;
      n_total++;
      if ({awaddr, wdata, wstrb} !== {32'h10, 32'hDEADBEEF, 4'hF})
         $display("FAIL wr_fields got %h %h %h want 10 deadbeef f",
                  awaddr, wdata, wstrb);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_total++;
         if ({awvalid, wvalid, bready} !== 3'b110)
            $display("FAIL wr_hold%0d got %b want 110", i,
                     {awvalid, wvalid, bready});
         else n_pass++;
      end
      awready = 1'b1;
      wready  = 1'b1;
      tick();
      awready = 1'b0;
      wready  = 1'b0;
      n_total++;
      if ({awvalid, wvalid, bready} !== 3'b001)
         $display("FAIL wr_b got %b want 001", {awvalid, wvalid, bready});
      else n_pass++;
      bvalid = 1'b1;
      bresp  = 2'b00;
      tick();
      bvalid = 1'b0;
      n_total++;
      if (bready !== 1'b0)
         $display("FAIL wr_bdrop got %b want 0", bready);
      else n_pass++;
      pop_cmp("write");
   endtask

   task automatic test_write_split();
      sb.push_back('{d: 32'h0, s: 2'b11});
      send(2'b01, 32'h14, 32'h0000_5A5A, 4'h3);
      awready = 1'b1;
      tick();
      awready = 1'b0;
      n_total++;
      if ({awvalid, wvalid, bready} !== 3'b010)
         $display("FAIL split_aw got %b want 010", {awvalid, wvalid, bready});
      else n_pass++;
      wready = 1'b1;
      tick();
      wready = 1'b0;
      n_total++;
      if ({awvalid, wvalid, bready} !== 3'b001)
         $display("FAIL split_w got %b want 001", {awvalid, wvalid, bready});
      else n_pass++;
      bvalid = 1'b1;
      bresp  = 2'b11;
      tick();
      bvalid = 1'b0;
      pop_cmp("write_split");
   endtask

   task automatic test_read();
      sb.push_back('{d: 32'h12345678, s: 2'b10});
      send(2'b00, 32'h20, 32'h0, 4'h0);
      n_total++;
      if ({arvalid, rready, araddr} !== {2'b10, 32'h20})
         $display("FAIL rd_a got %b %h want 10 20", {arvalid, rready}, araddr);
      else n_pass++;
      arready = 1'b1;
      tick();
      arready = 1'b0;
      n_total++;
      if ({arvalid, rready} !== 2'b01)
         $display("FAIL rd_d got %b want 01", {arvalid, rready});
      else n_pass++;
      rvalid = 1'b1;
      rdata  = 32'h12345678;
      rresp  = 2'b10;
      tick();
      rvalid = 1'b0;
      rdata  = 32'h0;
      pop_cmp("read");
   endtask

   task automatic test_run_fast();
      sb.push_back('{d: 32'h0, s: 2'b00});
      send(2'b10, 32'h0, 32'h0, 4'h0);
      n_total++;
      if (go_0r !== 1'b1)
         $display("FAIL fast_go got %b want 1", go_0r);
      else n_pass++;
      go_0a   = 1'b1;
      done_0r = 1'b1;
      tick();
      go_0a   = 1'b0;
      done_0r = 1'b0;
      n_total++;
      if (go_0r !== 1'b0)
         $display("FAIL fast_go_1cyc got %b want 0", go_0r);
      else n_pass++;
      pop_cmp("run_fast");
      n_total++;
      if ({cmd_ready, done_0a} !== 2'b10)
         $display("FAIL fast_idle got %b want 10", {cmd_ready, done_0a});
      else n_pass++;
   endtask

   task automatic test_run_long();
      int n;
      sb.push_back('{d: 32'd100, s: 2'b00});
      send(2'b10, 32'h0, 32'h0, 4'h0);
      go_0a = 1'b1;
      tick();
      go_0a = 1'b0;
      repeat (99) @(posedge clk);
      #1;
      done_0r = 1'b1;
      n = 0;
      while (!done_0a && n < 20) begin
         tick();
         n++;
      end
      n_total++;
      if ({done_0a, done_0r} !== 2'b11)
         $display("FAIL long_dack got %b want 11", {done_0a, done_0r});
      else n_pass++;
      done_0r = 1'b0;
      pop_cmp("run_long");
      n_total++;
      if (done_0a !== 1'b0)
         $display("FAIL long_dack_drop got %b want 0", done_0a);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [31:0] d0;
      sb.push_back('{d: 32'hA5A50001, s: 2'b00});
      send(2'b00, 32'h44, 32'h0, 4'h0);
      arready = 1'b1;
      tick();
      arready = 1'b0;
      rvalid = 1'b1;
      rdata  = 32'hA5A50001;
      rresp  = 2'b00;
      tick();
      rvalid = 1'b0;
      rdata  = 32'hFFFFFFFF;
      d0 = 32'hA5A50001;
      for (int i = 0; i < 5; i++) begin
         n_total++;
         if ({rsp_valid, cmd_ready, rsp_data} !== {2'b10, d0})
            $display("FAIL bp_hold%0d got %b %h want 10 %h", i,
                     {rsp_valid, cmd_ready}, rsp_data, d0);
         else n_pass++;
         tick();
      end
      pop_cmp("backpressure");
      n_total++;
      if ({cmd_ready, rsp_valid} !== 2'b10)
         $display("FAIL bp_after got %b want 10", {cmd_ready, rsp_valid});
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      send(2'b01, 32'h30, 32'h1, 4'h1);
      awready = 1'b1;
      wready  = 1'b1;
      tick();
      awready = 1'b0;
      wready  = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_total++;
      if ({cmd_ready, bready, awvalid, wvalid, rsp_valid} !== 5'b10000)
         $display("FAIL rst_wrb got %b want 10000",
                  {cmd_ready, bready, awvalid, wvalid, rsp_valid});
      else n_pass++;
      send(2'b10, 32'h0, 32'h0, 4'h0);
      go_0a = 1'b1;
      tick();
      go_0a = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_total++;
      if ({cmd_ready, go_0r, done_0a, rsp_valid, rsp_data} !== {4'b1000, 32'h0})
         $display("FAIL rst_run got %b %h want 1000 0",
                  {cmd_ready, go_0r, done_0a, rsp_valid}, rsp_data);
      else n_pass++;
   endtask

   task automatic test_reserved();
      sb.push_back('{d: 32'h0, s: 2'b10});
      send(2'b11, 32'h50, 32'h0, 4'h0);
      n_total++;
      if ({rsp_valid, arvalid, awvalid, wvalid, go_0r} !== 5'b10000)
         $display("FAIL rsvd_t1 got %b want 10000",
                  {rsp_valid, arvalid, awvalid, wvalid, go_0r});
      else n_pass++;
      pop_cmp("reserved");
   endtask

   initial begin
      reset = 1'b1;
      cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0;
      cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
      go_0a = 1'b0; done_0r = 1'b0;
      arready = 1'b0; rdata = '0; rresp = '0; rvalid = 1'b0;
      awready = 1'b0; wready = 1'b0; bresp = '0; bvalid = 1'b0;
      test_reset();
      test_write();
      test_write_split();
      test_read();
      test_run_fast();
      test_run_long();
      test_backpressure();
      test_reset_mid();
      test_reserved();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
